rf_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 8 x 32-bit register file's single write port. It shares the port between three write-back requesters (0 = ALU, 1 = load unit, 2 = debug/host) using round-robin arbitration with a valid/ready handshake. It drives a registered we/wa/wd triple straight into the register file. An 8-bit scoreboard tracks destinations reserved by issue and not yet written back.

---
 rtl/rf_wb_arbiter.sv | 115 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register-file write port, with a
// registered we/wa/wd stage and a per-register outstanding-write scoreboard.
module rf_wb_arbiter #(
    parameter int AW = 3,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v0,
    input  logic              v1,
    input  logic              v2,
    input  logic [AW-1:0]     a0,
    input  logic [AW-1:0]     a1,
    input  logic [AW-1:0]     a2,
    input  logic [DW-1:0]     d0,
    input  logic [DW-1:0]     d1,
    input  logic [DW-1:0]     d2,
    output logic              rdy0,
    output logic              rdy1,
    output logic              rdy2,
    input  logic              hold,
    input  logic              rsv_v,
    input  logic [AW-1:0]     rsv_a,
    output logic [(1<<AW)-1:0] busy,
    output logic              we,
    output logic [AW-1:0]     wa,
    output logic [DW-1:0]     wd
);
    localparam int NR = 1 << AW;

    logic [1:0]    ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [NR-1:0] busy_q, busy_d;

    logic [2:0] vld;
    logic [2:0] gnt;
    logic       gnt_any;
    logic [1:0] gnt_idx;

    assign vld = {v2, v1, v0};

    // Search starts one past the last grant; ptr only ever holds 0..2.
    always_comb begin
        gnt = 3'b000;
        if (!rst && !hold) begin
            case (ptr_q)
                2'd0: begin
                    if (vld[1])      gnt = 3'b010;
                    else if (vld[2]) gnt = 3'b100;
                    else if (vld[0]) gnt = 3'b001;
                end
                2'd1: begin
                    if (vld[2])      gnt = 3'b100;
                    else if (vld[0]) gnt = 3'b001;
                    else if (vld[1]) gnt = 3'b010;
                end
                default: begin
                    if (vld[0])      gnt = 3'b001;
                    else if (vld[1]) gnt = 3'b010;
                    else if (vld[2]) gnt = 3'b100;
                end
            endcase
        end
        gnt_any = |gnt;
    end

    always_comb begin
        gnt_idx = ptr_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        case (gnt)
            3'b001: begin gnt_idx = 2'd0; wa_d = a0; wd_d = d0; end
            3'b010: begin gnt_idx = 2'd1; wa_d = a1; wd_d = d1; end
            3'b100: begin gnt_idx = 2'd2; wa_d = a2; wd_d = d2; end
            default: ;
        endcase
        ptr_d = gnt_idx;
        we_d  = gnt_any;
    end

    // Reservation beats the clear of the write being committed at this edge.
    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_busy
            assign busy_d[gi] = (rsv_v && (rsv_a == AW'(gi))) ? 1'b1 :
                                (we_q && (wa_q == AW'(gi)))   ? 1'b0 :
                                busy_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= 2'd2;
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            busy_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            busy_q <= busy_d;
        end
    end

    assign rdy0 = gnt[0];
    assign rdy1 = gnt[1];
    assign rdy2 = gnt[2];
    assign we   = we_q;
    assign wa   = wa_q;
    assign wd   = wd_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: inputs change 1ns after posedge,
// outputs are checked at the following negedge.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 0, v1 = 0, v2 = 0;
    logic [2:0]  a0 = 0, a1 = 0, a2 = 0;
    logic [31:0] d0 = 0, d1 = 0, d2 = 0;
    logic        rdy0, rdy1, rdy2;
    logic        hold = 0;
    logic        rsv_v = 0;
    logic [2:0]  rsv_a = 0;
    logic [7:0]  busy;
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.AW(3), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .v0(v0), .v1(v1), .v2(v2),
        .a0(a0), .a1(a1), .a2(a2),
        .d0(d0), .d1(d1), .d2(d2),
        .rdy0(rdy0), .rdy1(rdy1), .rdy2(rdy2),
        .hold(hold), .rsv_v(rsv_v), .rsv_a(rsv_a),
        .busy(busy), .we(we), .wa(wa), .wd(wd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        v0 = 0; v1 = 0; v2 = 0; hold = 0; rsv_v = 0;
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; v0 = 1; v1 = 1; v2 = 1;
        a0 = 3'd1; a1 = 3'd2; a2 = 3'd3;
        d0 = 32'h1111_0000; d1 = 32'h2222_0000; d2 = 32'h3333_0000;
        step(); step();
        @(negedge clk);
        n_checks++;
        if ({rdy2, rdy1, rdy0} !== 3'b000) begin
            n_fail++; $display("FAIL reset_rdy: got %b want 000", {rdy2, rdy1, rdy0});
        end
        n_checks++;
        if ({we, wa, wd, busy} !== {1'b0, 3'd0, 32'd0, 8'h00}) begin
            n_fail++; $display("FAIL reset_outs: got we=%b wa=%0d wd=%h busy=%h want 0/0/0/00", we, wa, wd, busy);
        end
        step();
        rst = 0;
        @(negedge clk);
        n_checks++;
        if ({rdy2, rdy1, rdy0} !== 3'b001) begin
            n_fail++; $display("FAIL reset_first_grant: got %b want 001", {rdy2, rdy1, rdy0});
        end
        step();
        v0 = 0; v1 = 0; v2 = 0;
        @(negedge clk);
        n_checks++;
        if ({we, wa, wd} !== {1'b1, 3'd1, 32'h1111_0000}) begin
            n_fail++; $display("FAIL reset_first_write: got we=%b wa=%0d wd=%h want 1/1/11110000", we, wa, wd);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        v1 = 1; a1 = 3'd5; d1 = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++;
        if ({rdy2, rdy1, rdy0} !== 3'b010) begin
            n_fail++; $display("FAIL single_rdy: got %b want 010", {rdy2, rdy1, rdy0});
        end
        step();
        v1 = 0;
        @(negedge clk);
        n_checks++;
        if ({we, wa, wd} !== {1'b1, 3'd5, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL single_write: got we=%b wa=%0d wd=%h want 1/5/deadbeef", we, wa, wd);
        end
        n_checks++;
        if ({rdy2, rdy1, rdy0} !== 3'b000) begin
            n_fail++; $display("FAIL single_rdy_idle: got %b want 000", {rdy2, rdy1, rdy0});
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({we, wa, wd} !== {1'b0, 3'd5, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL single_after: got we=%b wa=%0d wd=%h want 0/5/deadbeef", we, wa, wd);
        end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        logic [31:0] dexp [3];
        logic [2:0]  aexp [3];
        dexp[0] = 32'hA0A0_0001; dexp[1] = 32'hB1B1_0002; dexp[2] = 32'hC2C2_0003;
        aexp[0] = 3'd1; aexp[1] = 3'd2; aexp[2] = 3'd4;
        do_reset();
        v0 = 1; v1 = 1; v2 = 1;
        a0 = aexp[0]; a1 = aexp[1]; a2 = aexp[2];
        d0 = dexp[0]; d1 = dexp[1]; d2 = dexp[2];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rdy2, rdy1, rdy0} !== (3'b001 << (i % 3))) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {rdy2, rdy1, rdy0}, 3'b001 << (i % 3));
            end
            if (i > 0) begin
                n_checks++;
                if ({we, wa, wd} !== {1'b1, aexp[(i-1)%3], dexp[(i-1)%3]}) begin
                    n_fail++; $display("FAIL rr_write[%0d]: got we=%b wa=%0d wd=%h want 1/%0d/%h", i, we, wa, wd, aexp[(i-1)%3], dexp[(i-1)%3]);
                end
            end
            step();
        end
        v0 = 0; v1 = 0; v2 = 0;
        @(negedge clk);
        n_checks++;
        if ({we, wa, wd} !== {1'b1, aexp[2], dexp[2]}) begin
            n_fail++; $display("FAIL rr_last_write: got we=%b wa=%0d wd=%h want 1/4/%h", we, wa, wd, dexp[2]);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (we !== 1'b0) begin
            n_fail++; $display("FAIL rr_idle_we: got %b want 0", we);
        end
        $display("test_round_robin done");
    endtask

    task automatic test_hold();
        logic       hold_v [7] = '{0, 0, 1, 1, 1, 0, 0};
        logic [2:0] rdy_v  [7] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001};
        logic       we_v   [7] = '{0, 1, 1, 0, 0, 0, 1};
        do_reset();
        v0 = 1; v1 = 1; v2 = 1;
        for (int i = 0; i < 7; i++) begin
            hold = hold_v[i];
            @(negedge clk);
            n_checks++;
            if ({rdy2, rdy1, rdy0} !== rdy_v[i]) begin
                n_fail++; $display("FAIL hold_rdy[%0d]: got %b want %b", i, {rdy2, rdy1, rdy0}, rdy_v[i]);
            end
            n_checks++;
            if (we !== we_v[i]) begin
                n_fail++; $display("FAIL hold_we[%0d]: got %b want %b", i, we, we_v[i]);
            end
            step();
        end
        v0 = 0; v1 = 0; v2 = 0; hold = 0;
        $display("test_hold done");
    endtask

    task automatic test_scoreboard();
        do_reset();
        rsv_v = 1; rsv_a = 3'd3;
        step();
        rsv_v = 0;
        @(negedge clk);
        n_checks++;
        if (busy !== 8'h08) begin
            n_fail++; $display("FAIL sb_set: got %h want 08", busy);
        end
        v0 = 1; a0 = 3'd3; d0 = 32'h0000_0033;
        step();                       // accept edge
        v0 = 0;
        @(negedge clk);
        n_checks++;
        if ({we, wa, busy} !== {1'b1, 3'd3, 8'h08}) begin
            n_fail++; $display("FAIL sb_we_cycle: got we=%b wa=%0d busy=%h want 1/3/08", we, wa, busy);
        end
        step();                       // commit edge
        @(negedge clk);
        n_checks++;
        if (busy !== 8'h00) begin
            n_fail++; $display("FAIL sb_clear: got %h want 00", busy);
        end
        rsv_v = 1; rsv_a = 3'd3;
        v0 = 1;
        step();                       // reserve + accept
        rsv_v = 0; v0 = 0;
        @(negedge clk);
        n_checks++;
        if ({we, busy} !== {1'b1, 8'h08}) begin
            n_fail++; $display("FAIL sb_rearm: got we=%b busy=%h want 1/08", we, busy);
        end
        rsv_v = 1; rsv_a = 3'd3;      // re-reserve on the clearing edge
        step();
        rsv_v = 0;
        @(negedge clk);
        n_checks++;
        if (busy !== 8'h08) begin
            n_fail++; $display("FAIL sb_set_wins: got %h want 08", busy);
        end
        v2 = 1; a2 = 3'd5; d2 = 32'h0000_0055;   // unreserved write
        step();
        v2 = 0;
        step();
        @(negedge clk);
        n_checks++;
        if (busy !== 8'h08) begin
            n_fail++; $display("FAIL sb_unreserved: got %h want 08", busy);
        end
        $display("test_scoreboard done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        v1 = 1; a1 = 3'd6; d1 = 32'h6666_6666;
        rsv_v = 1; rsv_a = 3'd6;
        step();                       // accept requester 1, reserve reg 6
        v1 = 0; rsv_v = 0;
        rst = 1; v2 = 1; a2 = 3'd7; d2 = 32'h7777_7777;
        @(negedge clk);
        n_checks++;
        if ({we, busy, rdy2, rdy1, rdy0} !== {1'b1, 8'h40, 3'b000}) begin
            n_fail++; $display("FAIL mid_pre: got we=%b busy=%h rdy=%b want 1/40/000", we, busy, {rdy2, rdy1, rdy0});
        end
        step();
        rst = 0; v0 = 1; v1 = 1;
        a0 = 3'd0; d0 = 32'h0000_00AA;
        @(negedge clk);
        n_checks++;
        if ({we, busy} !== {1'b0, 8'h00}) begin
            n_fail++; $display("FAIL mid_cleared: got we=%b busy=%h want 0/00", we, busy);
        end
        n_checks++;
        if ({rdy2, rdy1, rdy0} !== 3'b001) begin
            n_fail++; $display("FAIL mid_regrant: got %b want 001", {rdy2, rdy1, rdy0});
        end
        step();
        v0 = 0;
        @(negedge clk);
        n_checks++;
        if ({we, wa, wd, rdy2, rdy1, rdy0} !== {1'b1, 3'd0, 32'h0000_00AA, 3'b010}) begin
            n_fail++; $display("FAIL mid_resume: got we=%b wa=%0d wd=%h rdy=%b want 1/0/000000aa/010", we, wa, wd, {rdy2, rdy1, rdy0});
        end
        step();
        v1 = 0; v2 = 0;
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_scoreboard();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
